nzcv_flag_bank: RTL and testbench

Parametrised successor to the single NZCV status register. Holds the live condition flags with per-bit write enables, plus a LIFO of saved flag copies (SPSR-like) pushed on exception entry and popped on exception return. Also evaluates the 4-bit ARM condition field against the live flags. Sits between the ALU flag outputs and the decode/branch logic in the CPU datapath.

---
 rtl/nzcv_pkg.sv | 28 ++
 rtl/nzcv_flag_bank_if.sv | 35 +++
 rtl/nzcv_cond_eval.sv | 42 ++++
 rtl/nzcv_flag_bank.sv | 115 +++++++++++
 tb/tb_nzcv_flag_bank.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/nzcv_pkg.sv
// nzcv_pkg: constants shared by the NZCV flag bank and the branch unit.
//   - FLAG_* : bit positions of N, Z, C, V inside the flag word.
//   - COND_* : 4-bit ARM condition-field encodings.
package nzcv_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/nzcv_flag_bank_if.sv
// nzcv_flag_bank_if: control/status bundle of the flag bank.
//   Requester side (master) drives: we, d, save, restore, err_clr, cond.
//   Bank side (slave) drives: q, top, depth, full, empty, cond_pass, err_ovf, err_unf.
interface nzcv_flag_bank_if #(
    parameter int unsigned NUM_FLAGS   = 4,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

    logic [NUM_FLAGS-1:0] we;
    logic [NUM_FLAGS-1:0] d;
    logic                 save;
    logic                 restore;
    logic                 err_clr;
    logic [3:0]           cond;
    logic [NUM_FLAGS-1:0] q;
    logic [NUM_FLAGS-1:0] top;
    logic [DW-1:0]        depth;
    logic                 full;
    logic                 empty;
    logic                 cond_pass;
    logic                 err_ovf;
    logic                 err_unf;

    modport master (
        output we, d, save, restore, err_clr, cond,
        input  q, top, depth, full, empty, cond_pass, err_ovf, err_unf
    );

    modport slave (
        input  we, d, save, restore, err_clr, cond,
        output q, top, depth, full, empty, cond_pass, err_ovf, err_unf
    );

endinterface

// File: rtl/nzcv_cond_eval.sv
// nzcv_cond_eval: purely combinational ARM condition-field evaluator.
//   flags : {N, Z, C, V}
//   cond  : 4-bit condition field
//   pass  : 1 when the condition holds for the given flags
module nzcv_cond_eval
    import nzcv_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/nzcv_flag_bank.sv
// nzcv_flag_bank: live condition flags with per-bit write enables, a LIFO of
// saved copies for exception entry/return, and condition-field evaluation.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : nzcv_flag_bank_if slave modport (controls in, flags/status out)
module nzcv_flag_bank
    import nzcv_pkg::*;
#(
    parameter int unsigned NUM_FLAGS   = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    nzcv_flag_bank_if.slave bus
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

    logic [NUM_FLAGS-1:0] q_q, q_d;
    logic [NUM_FLAGS-1:0] stack_q [STACK_DEPTH];
    logic [NUM_FLAGS-1:0] stack_d [STACK_DEPTH];
    logic [DW-1:0]        depth_q, depth_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_unf_q, err_unf_d;

    logic                 full, empty;
    logic                 push_req, pop_req;
    logic                 do_push, do_pop;
    logic [NUM_FLAGS-1:0] top_val;
    logic                 pass;

    assign full  = (depth_q == DW'(STACK_DEPTH));
    assign empty = (depth_q == '0);

    // Simultaneous SAVE and RESTORE cancel each other completely.
    assign push_req = bus.save & ~bus.restore;
    assign pop_req  = bus.restore & ~bus.save;
    assign do_push  = push_req & ~full;
    assign do_pop   = pop_req & ~empty;

    // Compare against each entry index rather than indexing with depth_q,
    // whose width exceeds the array index width.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_val = stack_q[i];
            end
        end
    end

    always_comb begin
        stack_d = stack_q;
        if (do_push) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                if (depth_q == DW'(i)) begin
                    stack_d[i] = q_q;
                end
            end
        end
    end

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + 1'b1;
        end else if (do_pop) begin
            depth_d = depth_q - 1'b1;
        end
    end

    // A successful pop overrides the per-bit write.
    always_comb begin
        q_d = (q_q & ~bus.we) | (bus.d & bus.we);
        if (do_pop) begin
            q_d = top_val;
        end
    end

    // New error events take precedence over a same-cycle clear.
    assign err_ovf_d = (push_req & full) | (err_ovf_q & ~bus.err_clr);
    assign err_unf_d = (pop_req & empty) | (err_unf_q & ~bus.err_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= '0;
            stack_q   <= '{default: '0};
            depth_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            stack_q   <= stack_d;
            depth_q   <= depth_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    nzcv_cond_eval u_cond_eval (
        .flags (q_q[FLAG_N:FLAG_V]),
        .cond  (bus.cond),
        .pass  (pass)
    );

    assign bus.q         = q_q;
    assign bus.top       = top_val;
    assign bus.depth     = depth_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.cond_pass = pass;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_unf   = err_unf_q;

endmodule

// File: tb/tb_nzcv_flag_bank.sv
// tb_nzcv_flag_bank: directed self-checking bench for nzcv_flag_bank.
module tb_nzcv_flag_bank;

    localparam int unsigned NF = 4;
    localparam int unsigned SD = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    nzcv_flag_bank_if #(.NUM_FLAGS(NF), .STACK_DEPTH(SD)) bus ();

    nzcv_flag_bank #(.NUM_FLAGS(NF), .STACK_DEPTH(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply current inputs at one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we      = '0;
        bus.d       = '0;
        bus.save    = 1'b0;
        bus.restore = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    // Independent reference of the ARM condition table, f = {N,Z,C,V}.
    function automatic logic ref_pass(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        bus.cond = 4'd0;
        rst = 1'b1;
        #2;
        check("rst_q", 32'(bus.q), 32'h0);
        check("rst_depth", 32'(bus.depth), 32'h0);
        check("rst_empty", 32'(bus.empty), 32'h1);
        check("rst_full", 32'(bus.full), 32'h0);
        check("rst_top", 32'(bus.top), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Per-bit write and hold.
        bus.we = 4'b1110; bus.d = 4'b1111;
        tick();
        idle();
        check("we_q", 32'(bus.q), 32'hE);
        tick();
        check("hold_q", 32'(bus.q), 32'hE);
        bus.cond = 4'b0000; #1;
        check("cond_eq", 32'(bus.cond_pass), 32'h1);
        bus.cond = 4'b0110; #1;
        check("cond_vs", 32'(bus.cond_pass), 32'h0);
        bus.cond = 4'b1000; #1;
        check("cond_hi", 32'(bus.cond_pass), 32'h0);

        // SAVE with concurrent write, then RESTORE overriding a write.
        bus.we = 4'b1111; bus.d = 4'b0010;
        tick();
        bus.save = 1'b1; bus.we = 4'b1111; bus.d = 4'b0100;
        tick();
        idle();
        check("save_top", 32'(bus.top), 32'h2);
        check("save_q", 32'(bus.q), 32'h4);
        check("save_depth", 32'(bus.depth), 32'h1);
        bus.restore = 1'b1; bus.we = 4'b1111; bus.d = 4'b1111;
        tick();
        idle();
        check("restore_q", 32'(bus.q), 32'h2);
        check("restore_depth", 32'(bus.depth), 32'h0);
        check("restore_empty", 32'(bus.empty), 32'h1);

        // Five saves into a four-deep stack; each also writes a new Q.
        for (int k = 0; k < 5; k++) begin
            bus.save = 1'b1; bus.we = 4'b1111; bus.d = 4'(3 + k);
            tick();
        end
        idle();
        check("ovf_depth", 32'(bus.depth), 32'h4);
        check("ovf_full", 32'(bus.full), 32'h1);
        check("ovf_err", 32'(bus.err_ovf), 32'h1);
        check("ovf_top", 32'(bus.top), 32'h5);
        check("ovf_q", 32'(bus.q), 32'h7);
        check("ovf_unf", 32'(bus.err_unf), 32'h0);
        bus.err_clr = 1'b1;
        tick();
        idle();
        check("clr_ovf", 32'(bus.err_ovf), 32'h0);

        // Pop two entries, load Q = 1010, then reset between edges.
        bus.restore = 1'b1;
        tick();
        check("pop1_q", 32'(bus.q), 32'h5);
        tick();
        idle();
        check("pop2_q", 32'(bus.q), 32'h4);
        check("pop2_depth", 32'(bus.depth), 32'h2);
        bus.we = 4'b1111; bus.d = 4'b1010;
        tick();
        idle();
        check("pre_rst_q", 32'(bus.q), 32'hA);
        bus.save = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_q", 32'(bus.q), 32'h0);
        check("arst_depth", 32'(bus.depth), 32'h0);
        check("arst_empty", 32'(bus.empty), 32'h1);
        check("arst_ovf", 32'(bus.err_ovf), 32'h0);
        check("arst_unf", 32'(bus.err_unf), 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        // Underflow with a concurrent write.
        bus.restore = 1'b1; bus.we = 4'b0001; bus.d = 4'b0001;
        tick();
        idle();
        check("unf_err", 32'(bus.err_unf), 32'h1);
        check("unf_q", 32'(bus.q), 32'h1);
        check("unf_depth", 32'(bus.depth), 32'h0);

        // SAVE and RESTORE together at depth 2.
        bus.save = 1'b1; bus.we = 4'b1111; bus.d = 4'b0011;
        tick();
        bus.we = '0; bus.d = '0;
        tick();
        idle();
        check("pre_both_depth", 32'(bus.depth), 32'h2);
        bus.save = 1'b1; bus.restore = 1'b1; bus.we = 4'b1000; bus.d = 4'b1000;
        tick();
        idle();
        check("both_depth", 32'(bus.depth), 32'h2);
        check("both_ovf", 32'(bus.err_ovf), 32'h0);
        check("both_top", 32'(bus.top), 32'h3);
        check("both_q", 32'(bus.q), 32'hB);

        // Clear and new underflow event in one cycle: the event wins.
        for (int k = 0; k < 2; k++) begin
            bus.restore = 1'b1;
            tick();
        end
        idle();
        check("drain_empty", 32'(bus.empty), 32'h1);
        bus.restore = 1'b1; bus.err_clr = 1'b1;
        tick();
        idle();
        check("clr_vs_evt", 32'(bus.err_unf), 32'h1);
        bus.err_clr = 1'b1;
        tick();
        idle();
        check("clr_unf", 32'(bus.err_unf), 32'h0);

        // Full condition table sweep.
        for (int f = 0; f < 16; f++) begin
            bus.we = 4'b1111; bus.d = 4'(f);
            tick();
            idle();
            for (int c = 0; c < 16; c++) begin
                bus.cond = 4'(c);
                #1;
                check($sformatf("cond_f%0d_c%0d", f, c), 32'(bus.cond_pass),
                      32'(ref_pass(4'(f), 4'(c))));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
